// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: splits 32-bit loads/stores into two half-word SRAM cycles and freezes the pipe via ready.
// Optional range check enabled by defining MEM_CTRL_ADDR_CHECK_EN.
module mem_access_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        ST_val,
  output logic               ready,
  output logic [31:0]        MEM_read_data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  input  logic [15:0]        SRAM_DQ_in,
  output logic               SRAM_WE_N,
  output logic               addr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  LP_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] LP_BASE = 32'(BASE_ADDR);

  state_t             r_state, w_next_state;
  logic [3:0]         r_cnt, w_next_cnt;
  logic               r_wr, w_next_wr;
  logic [SRAM_AW-2:0] r_word, w_next_word;
  logic [15:0]        r_st_hi;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_addr;
  logic [15:0]        r_dq_out;
  logic               r_oe, r_we_n, r_addr_err;
  logic               w_req, w_bad, w_next_bad, w_next_phase;
  logic               w_enter_low, w_enter_high, w_lo_cap, w_hi_cap, w_bad_load;
  logic [31:0]        w_off;
  logic               w_unused;

  assign w_req = MEM_R_EN | MEM_W_EN;
  assign w_off = ALU_Res - LP_BASE;
  assign w_unused = ^{w_off[1:0], w_off[31:SRAM_AW+1]};

`ifdef MEM_CTRL_ADDR_CHECK_EN
  assign w_bad = (ALU_Res < LP_BASE) || (w_off[31:SRAM_AW+1] != {(31-SRAM_AW){1'b0}});
`else
  assign w_bad = 1'b0;
`endif

  // Next-state, phase counter and latched access attributes
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_wr    = r_wr;
    w_next_word  = r_word;
    w_next_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = 4'd0;
        if (w_req) begin
          w_next_wr   = MEM_W_EN;
          w_next_word = w_off[SRAM_AW:2];
          if (w_bad) begin
            w_next_state = S_DONE;
            w_next_bad   = 1'b1;
          end else begin
            w_next_state = S_LOW;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOW: begin
        if (r_cnt == LP_LAST) begin
          w_next_state = S_HIGH;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end
      S_HIGH: begin
        if (r_cnt == LP_LAST) begin
          w_next_state = S_DONE;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  assign w_next_phase = (w_next_state == S_LOW) || (w_next_state == S_HIGH);
  assign w_enter_low  = (r_state == S_IDLE) && (w_next_state == S_LOW);
  assign w_enter_high = (r_state == S_LOW) && (w_next_state == S_HIGH);
  assign w_lo_cap     = (r_state == S_LOW) && (r_cnt == LP_LAST) && !r_wr;
  assign w_hi_cap     = (r_state == S_HIGH) && (r_cnt == LP_LAST) && !r_wr;
  assign w_bad_load   = (r_state == S_IDLE) && (w_next_state == S_DONE) && !w_next_wr;

  // State register and registered SRAM strobes; WE_N releases one cycle early for data hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wr       <= 1'b0;
      r_word     <= {(SRAM_AW-1){1'b0}};
      r_st_hi    <= 16'h0000;
      r_rdata    <= 32'h0000_0000;
      r_addr     <= {SRAM_AW{1'b0}};
      r_dq_out   <= 16'h0000;
      r_oe       <= 1'b0;
      r_we_n     <= 1'b1;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_wr       <= w_next_wr;
      r_word     <= w_next_word;
      r_oe       <= w_next_phase & w_next_wr;
      r_we_n     <= ~(w_next_phase & w_next_wr & (w_next_cnt < LP_LAST));
      r_addr_err <= w_next_bad;
      if (w_enter_low) begin
        r_addr   <= {w_next_word, 1'b0};
        r_dq_out <= ST_val[15:0];
        r_st_hi  <= ST_val[31:16];
      end else if (w_enter_high) begin
        r_addr   <= {r_word, 1'b1};
        r_dq_out <= r_st_hi;
      end
      if (w_lo_cap) begin
        r_rdata[15:0] <= SRAM_DQ_in;
      end else if (w_hi_cap) begin
        r_rdata[31:16] <= SRAM_DQ_in;
      end else if (w_bad_load) begin
        r_rdata <= 32'h0000_0000;
      end
    end
  end

  assign ready         = rst | ~w_req | (r_state == S_DONE);
  assign MEM_read_data = r_rdata;
  assign SRAM_ADDR     = r_addr;
  assign SRAM_DQ_out   = r_dq_out;
  assign SRAM_DQ_oe    = r_oe;
  assign SRAM_WE_N     = r_we_n;
  assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, corner sequences and random accesses vs a word-level model.
module tb_mem_access_ctrl;
  localparam int WAIT = 3;
  localparam int LAT  = 2 * WAIT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] ALU_Res = 32'h0, ST_val = 32'h0;
  logic        ready, SRAM_DQ_oe, SRAM_WE_N, addr_err;
  logic [31:0] MEM_read_data;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;

  logic [15:0] sram [0:1023];
  logic [31:0] m_mem [int];
  logic [31:0] m_last_rd = 32'h0;
  int n_vec = 0, n_err = 0;

  mem_access_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(WAIT), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .ST_val(ST_val), .ready(ready), .MEM_read_data(MEM_read_data),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N), .addr_err(addr_err));

  always #5 clk = ~clk;

  // Asynchronous SRAM: reads follow the address, writes land while WE_N is low
  assign SRAM_DQ_in = sram[SRAM_ADDR[9:0]];
  always @(posedge clk) if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR[9:0]] <= SRAM_DQ_out;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] exp_rd;
    int          exp_we;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    int          lo_idx;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return int'((o / 32'd4) % 32'd131072);
  endfunction

  function automatic logic [31:0] model_read(input int w);
    return m_mem.exists(w) ? m_mem[w] : 32'h0;
  endfunction

  task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] st);
    if (wr) m_mem[word_of(a)] = st;
    else if (rd) m_last_rd = model_read(word_of(a));
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] st,
                           output int lat, output int we_lows, output int oe_hi, output int err_hi);
    @(negedge clk);
    MEM_R_EN = rd; MEM_W_EN = wr; ALU_Res = a; ST_val = st;
    #1;
    lat = -1; we_lows = 0; oe_hi = 0; err_hi = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (!SRAM_WE_N) we_lows++;
      if (SRAM_DQ_oe) oe_hi++;
      if (addr_err) err_hi++;
      if (ready) begin
        lat = c;
        break;
      end
    end
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  task automatic run_checked(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] st);
    int lat, wl, oe, er;
    do_access(rd, wr, a, st, lat, wl, oe, er);
    model_apply(rd, wr, a, st);
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_rdata"}, MEM_read_data, m_last_rd);
    chk({tag, "_we_lows"}, 32'(wl), wr ? 32'(2 * (WAIT - 1)) : 32'd0);
    chk({tag, "_oe_cycles"}, 32'(oe), wr ? 32'(2 * WAIT) : 32'd0);
    chk({tag, "_addr_err"}, 32'(er), 32'd0);
    if (wr) begin
      chk({tag, "_sram_lo"}, {16'h0, sram[2 * word_of(a)]}, {16'h0, st[15:0]});
      chk({tag, "_sram_hi"}, {16'h0, sram[2 * word_of(a) + 1]}, {16'h0, st[31:16]});
    end
  endtask

  initial begin
    int lat, wl, oe, er, c1, c2;
    logic [31:0] exp1;
    for (int i = 0; i < 1024; i++) sram[i] = 16'h0;

    vecs.push_back('{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000, 4, 16'hBEEF, 16'hDEAD, 2});
    vecs.push_back('{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, 0, 16'h0,    16'h0,    -1});
    vecs.push_back('{1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 4, 16'h5678, 16'h1234, 4});
    vecs.push_back('{1'b1, 1'b0, 32'd1032, 32'h0,        32'h12345678, 0, 16'h0,    16'h0,    -1});
    vecs.push_back('{1'b0, 1'b1, 32'd1039, 32'hA5A55A5A, 32'h12345678, 4, 16'h5A5A, 16'hA5A5, 6});
    vecs.push_back('{1'b1, 1'b0, 32'd1036, 32'h0,        32'hA5A55A5A, 0, 16'h0,    16'h0,    -1});
`ifndef MEM_CTRL_ADDR_CHECK_EN
    vecs.push_back('{1'b0, 1'b1, 32'd525312, 32'h0F0FF0F0, 32'hA5A55A5A, 4, 16'hF0F0, 16'h0F0F, 0});
    vecs.push_back('{1'b1, 1'b0, 32'd1024,   32'h0,        32'h0F0FF0F0, 0, 16'h0,    16'h0,    -1});
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready_forced", {31'h0, ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'd1);
    chk("rst_we_n", {31'h0, SRAM_WE_N}, 32'd1);
    chk("rst_oe", {31'h0, SRAM_DQ_oe}, 32'd0);
    chk("rst_addr", {14'h0, SRAM_ADDR}, 32'd0);
    chk("rst_dq_out", {16'h0, SRAM_DQ_out}, 32'd0);
    chk("rst_rdata", MEM_read_data, 32'd0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'd0);

    foreach (vecs[i]) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].st, lat, wl, oe, er);
      model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].st);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
      chk($sformatf("vec%0d_rdata", i), MEM_read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_we_lows", i), 32'(wl), 32'(vecs[i].exp_we));
      if (!vecs[i].wr) chk($sformatf("vec%0d_oe_on_load", i), 32'(oe), 32'd0);
      if (vecs[i].lo_idx >= 0) begin
        chk($sformatf("vec%0d_sram_lo", i), {16'h0, sram[vecs[i].lo_idx]}, {16'h0, vecs[i].exp_lo});
        chk($sformatf("vec%0d_sram_hi", i), {16'h0, sram[vecs[i].lo_idx + 1]}, {16'h0, vecs[i].exp_hi});
      end
    end

    // Back-to-back loads: request held through DONE with a new address
    @(negedge clk);
    MEM_R_EN = 1'b1; ALU_Res = 32'd1028;
    #1;
    c1 = -1; c2 = -1;
    for (int c = 0; c < 40 && c2 < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (ready && c1 < 0) begin
        c1 = c;
        exp1 = model_read(word_of(32'd1028));
        chk("b2b_first_rdata", MEM_read_data, exp1);
        ALU_Res = 32'd1024;
      end else if (ready) begin
        c2 = c;
      end
    end
    MEM_R_EN = 1'b0;
    m_last_rd = model_read(word_of(32'd1024));
    chk("b2b_first_lat", 32'(c1), 32'(LAT));
    chk("b2b_gap", 32'(c2 - c1), 32'(LAT + 1));
    chk("b2b_second_rdata", MEM_read_data, m_last_rd);

    // Reset asserted during the HIGH phase of a store
    @(negedge clk);
    MEM_W_EN = 1'b1; ALU_Res = 32'd1424; ST_val = 32'hCAFEF00D;
    repeat (5) @(negedge clk);
    chk("midrst_pre_we_n", {31'h0, SRAM_WE_N}, 32'd0);
    chk("midrst_pre_addr", {14'h0, SRAM_ADDR}, 32'd201);
    rst = 1'b1;
    #1;
    chk("midrst_ready_forced", {31'h0, ready}, 32'd1);
    @(negedge clk);
    chk("midrst_we_n", {31'h0, SRAM_WE_N}, 32'd1);
    chk("midrst_oe", {31'h0, SRAM_DQ_oe}, 32'd0);
    chk("midrst_rdata", MEM_read_data, 32'd0);
    chk("midrst_addr", {14'h0, SRAM_ADDR}, 32'd0);
    rst = 1'b0; MEM_W_EN = 1'b0;
    m_last_rd = 32'h0;
    run_checked("post_rst_load", 1'b1, 1'b0, 32'd1028, 32'h0);

`ifdef MEM_CTRL_ADDR_CHECK_EN
    do_access(1'b1, 1'b0, 32'd512, 32'h0, lat, wl, oe, er);
    m_last_rd = 32'h0;
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_addr_err", 32'(er), 32'd1);
    chk("oor_rdata", MEM_read_data, 32'd0);
    chk("oor_we_lows", 32'(wl), 32'd0);
    @(negedge clk);
    chk("oor_err_one_cycle", {31'h0, addr_err}, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [31:0] a;
      op = 2'($urandom_range(0, 2));
      a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      run_checked($sformatf("rnd%0d", i), op != 2'd1, op != 2'd0, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
